// File: rtl/branch_resolution_unit.sv
// EX-stage branch resolution: carries predicted next-PC down IF/ID/EX,
// resolves branches/jumps, drives flush and predictor feedback.
package branch_resolution_unit_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pred;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pred;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } id_ex_t;

endpackage

module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pc_predict,
  input  logic             stall,
  input  logic             id_is_branch,
  input  logic             id_is_jal,
  input  logic             id_is_jalr,
  input  logic [2:0]       id_funct3,
  input  logic [31:0]      id_imm,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_rs2,
  output logic [31:0]      ex_pc,
  output logic [31:0]      pc_correct,
  output logic             prediction_success,
  output logic             resolve_valid,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  if_id_t if_id;
  id_ex_t id_ex;

  logic        taken;
  logic        sel_jalr;
  logic        sel_tgt;
  logic        sel_seq;
  logic [31:0] jalr_sum;
  logic [31:0] tgt;
  logic [31:0] seq;

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id <= '0;
      id_ex <= '0;
    end else if (flush) begin
      if_id.valid <= 1'b0;
      id_ex.valid <= 1'b0;
    end else if (stall) begin
      id_ex.valid <= 1'b0;
    end else begin
      if_id.valid     <= if_valid;
      if_id.pc        <= if_pc;
      if_id.pred      <= if_pc_predict;
      id_ex.valid     <= if_id.valid;
      id_ex.pc        <= if_id.pc;
      id_ex.pred      <= if_id.pred;
      id_ex.is_branch <= id_is_branch;
      id_ex.is_jal    <= id_is_jal;
      id_ex.is_jalr   <= id_is_jalr;
      id_ex.funct3    <= id_funct3;
      id_ex.imm       <= id_imm;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (id_ex.funct3)
      3'b000:  taken = (ex_rs1 == ex_rs2);
      3'b001:  taken = (ex_rs1 != ex_rs2);
      3'b100:  taken = ($signed(ex_rs1) < $signed(ex_rs2));
      3'b101:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  taken = (ex_rs1 < ex_rs2);
      3'b111:  taken = (ex_rs1 >= ex_rs2);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum = ex_rs1 + id_ex.imm;
  assign tgt      = id_ex.pc + id_ex.imm;
  assign seq      = id_ex.pc + 32'd4;

  // One-hot select keeps the jalr > jal > taken-branch priority explicit
  assign sel_jalr = id_ex.is_jalr;
  assign sel_tgt  = !id_ex.is_jalr &&
                    (id_ex.is_jal || (id_ex.is_branch && taken));
  assign sel_seq  = !sel_jalr && !sel_tgt;

  always_comb begin
    pc_correct = seq;
    unique case (1'b1)
      sel_jalr: pc_correct = {jalr_sum[31:1], 1'b0};
      sel_tgt:  pc_correct = tgt;
      sel_seq:  pc_correct = seq;
      default:  pc_correct = seq;
    endcase
  end

  assign ex_pc              = id_ex.pc;
  assign prediction_success = !id_ex.valid ||
                              (pc_correct == id_ex.pred);
  assign flush              = id_ex.valid && !prediction_success;
  assign resolve_valid      = id_ex.valid &&
                              (id_ex.is_branch ||
                               id_ex.is_jal ||
                               id_ex.is_jalr);

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (resolve_valid && (branch_count != '1))
        branch_count <= branch_count + CNT_W'(1);
      if (flush && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit; narrow counters
// let saturation be reached with a short loop.
module tb_branch_resolution_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc_predict;
  logic          stall;
  logic          id_is_branch;
  logic          id_is_jal;
  logic          id_is_jalr;
  logic [2:0]    id_funct3;
  logic [31:0]   id_imm;
  logic [31:0]   ex_rs1;
  logic [31:0]   ex_rs2;
  logic [31:0]   ex_pc;
  logic [31:0]   pc_correct;
  logic          prediction_success;
  logic          resolve_valid;
  logic          flush;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_resolution_unit #(.CNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .if_valid           (if_valid),
    .if_pc              (if_pc),
    .if_pc_predict      (if_pc_predict),
    .stall              (stall),
    .id_is_branch       (id_is_branch),
    .id_is_jal          (id_is_jal),
    .id_is_jalr         (id_is_jalr),
    .id_funct3          (id_funct3),
    .id_imm             (id_imm),
    .ex_rs1             (ex_rs1),
    .ex_rs2             (ex_rs2),
    .ex_pc              (ex_pc),
    .pc_correct         (pc_correct),
    .prediction_success (prediction_success),
    .resolve_valid      (resolve_valid),
    .flush              (flush),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_id();
    id_is_branch = 1'b0;
    id_is_jal    = 1'b0;
    id_is_jalr   = 1'b0;
    id_funct3    = 3'b000;
    id_imm       = 32'h0;
  endtask

  // Fetch one instruction, decode it, leave it sitting in EX
  task automatic issue(logic [31:0] pc,
                       logic [31:0] pred,
                       logic br, logic jal, logic jalr,
                       logic [2:0] f3,
                       logic [31:0] imm);
    if_valid      = 1'b1;
    if_pc         = pc;
    if_pc_predict = pred;
    tick();
    if_valid     = 1'b0;
    id_is_branch = br;
    id_is_jal    = jal;
    id_is_jalr   = jalr;
    id_funct3    = f3;
    id_imm       = imm;
    tick();
    clear_id();
  endtask

  initial begin
    reset         = 1'b1;
    if_valid      = 1'b0;
    if_pc         = 32'h0;
    if_pc_predict = 32'h0;
    stall         = 1'b0;
    ex_rs1        = 32'h0;
    ex_rs2        = 32'h0;
    clear_id();
    tick();
    tick();

    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_pc_correct", pc_correct, 32'h4);
    check("rst_succ", 32'(prediction_success), 32'h1);
    check("rst_rv", 32'(resolve_valid), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_flush", 32'(flush), 32'h0);
    check("idle_bc", 32'(branch_count), 32'h0);
    check("idle_mc", 32'(mispredict_count), 32'h0);

    // BEQ taken but predicted fall-through; a younger
    // mispredicting instruction follows and must be killed.
    if_valid      = 1'b1;
    if_pc         = 32'h100;
    if_pc_predict = 32'h104;
    tick();
    id_is_branch  = 1'b1;
    id_funct3     = 3'b000;
    id_imm        = 32'h20;
    if_pc         = 32'h300;
    if_pc_predict = 32'h500;
    tick();
    clear_id();
    if_valid = 1'b0;
    ex_rs1   = 32'd5;
    ex_rs2   = 32'd5;
    #1;
    check("beq_ex_pc", ex_pc, 32'h100);
    check("beq_pc", pc_correct, 32'h120);
    check("beq_flush", 32'(flush), 32'h1);
    check("beq_rv", 32'(resolve_valid), 32'h1);
    tick();
    check("beq_post_flush", 32'(flush), 32'h0);
    check("beq_post_rv", 32'(resolve_valid), 32'h0);
    check("beq_bc", 32'(branch_count), 32'h1);
    check("beq_mc", 32'(mispredict_count), 32'h1);
    tick();
    check("killed_flush", 32'(flush), 32'h0);
    check("killed_mc", 32'(mispredict_count), 32'h1);

    // BLT signed: -1 < 1, taken, correctly predicted
    issue(32'h100, 32'h120, 1, 0, 0, 3'b100, 32'h20);
    ex_rs1 = 32'hFFFF_FFFF;
    ex_rs2 = 32'h1;
    #1;
    check("blt_pc", pc_correct, 32'h120);
    check("blt_succ", 32'(prediction_success), 32'h1);
    check("blt_flush", 32'(flush), 32'h0);
    tick();
    check("blt_bc", 32'(branch_count), 32'h2);
    check("blt_mc", 32'(mispredict_count), 32'h1);

    // BLTU: 0xFFFFFFFF is not below 1, so falls through
    issue(32'h100, 32'h120, 1, 0, 0, 3'b110, 32'h20);
    #1;
    check("bltu_pc", pc_correct, 32'h104);
    check("bltu_flush", 32'(flush), 32'h1);
    tick();
    check("bltu_bc", 32'(branch_count), 32'h3);
    check("bltu_mc", 32'(mispredict_count), 32'h2);

    // JALR clears bit 0 of the target
    issue(32'h400, 32'h202, 0, 0, 1, 3'b000, 32'h0);
    ex_rs1 = 32'h203;
    #1;
    check("jalr_pc", pc_correct, 32'h202);
    check("jalr_flush", 32'(flush), 32'h0);
    check("jalr_rv", 32'(resolve_valid), 32'h1);
    tick();
    check("jalr_bc", 32'(branch_count), 32'h4);

    // JAL with negative offset
    issue(32'h1000, 32'hFF0, 0, 1, 0, 3'b000, 32'hFFFF_FFF0);
    #1;
    check("jal_pc", pc_correct, 32'hFF0);
    check("jal_flush", 32'(flush), 32'h0);
    tick();
    check("jal_bc", 32'(branch_count), 32'h5);

    // BNE held in IF/ID by a 3-cycle stall
    if_valid      = 1'b1;
    if_pc         = 32'h500;
    if_pc_predict = 32'h504;
    tick();
    stall         = 1'b1;
    id_is_branch  = 1'b1;
    id_funct3     = 3'b001;
    id_imm        = 32'h40;
    if_pc         = 32'h777;
    if_pc_predict = 32'h0;
    ex_rs1        = 32'd7;
    ex_rs2        = 32'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rv", 32'(resolve_valid), 32'h0);
      check("stall_flush", 32'(flush), 32'h0);
    end
    stall    = 1'b0;
    if_valid = 1'b0;
    tick();
    clear_id();
    #1;
    check("bne_ex_pc", ex_pc, 32'h500);
    check("bne_rv", 32'(resolve_valid), 32'h1);
    check("bne_pc", pc_correct, 32'h504);
    check("bne_flush", 32'(flush), 32'h0);
    tick();
    check("bne_bc", 32'(branch_count), 32'h6);
    tick();
    check("bne_once_rv", 32'(resolve_valid), 32'h0);
    check("bne_once_bc", 32'(branch_count), 32'h6);

    // Non-control instruction aliasing at the top of memory
    issue(32'hFFFF_FFFC, 32'h40, 0, 0, 0, 3'b000, 32'h0);
    #1;
    check("wrap_pc", pc_correct, 32'h0);
    check("wrap_flush", 32'(flush), 32'h1);
    check("wrap_rv", 32'(resolve_valid), 32'h0);
    tick();
    check("wrap_bc", 32'(branch_count), 32'h6);
    check("wrap_mc", 32'(mispredict_count), 32'h3);

    // Drive both counters past all-ones
    for (int i = 0; i < 14; i++) begin
      issue(32'h0, 32'h0, 0, 1, 0, 3'b000, 32'h8);
      tick();
    end
    check("sat_bc", 32'(branch_count), 32'hF);
    check("sat_mc", 32'(mispredict_count), 32'hF);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
